// File: rtl/arb_requester_if.sv
`default_nettype none
// ============================================================================
// Module  : arb_requester_if
// Purpose : Input-buffer, arbiter and crossbar signals of one switch input port
// Rev     : 1.0
// ============================================================================
interface arb_requester_if #(
    parameter int NUM_OUTPUTS = 4,
    parameter int NUM_INPUTS  = 4,
    parameter int FLIT_W      = 32,
    parameter int DEST_W      = 4
);
    localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic                         in_valid;
    logic                         in_ready;
    logic [FLIT_W-1:0]            in_data;
    logic                         in_last;
    logic [NUM_OUTPUTS-1:0]       bid;
    logic [NUM_OUTPUTS*SEL_W-1:0] sel;
    logic [NUM_OUTPUTS-1:0]       sel_valid;
    logic                         out_valid;
    logic                         out_ready;
    logic [FLIT_W-1:0]            out_data;
    logic                         out_last;
    logic [DEST_W-1:0]            out_dest;
    logic                         drop_err;

    // Requester side
    modport master (
        input  in_valid, in_data, in_last, sel, sel_valid, out_ready,
        output in_ready, bid, out_valid, out_data, out_last, out_dest, drop_err
    );

    // Environment side: input buffer, arbiters and crossbar
    modport slave (
        output in_valid, in_data, in_last, sel, sel_valid, out_ready,
        input  in_ready, bid, out_valid, out_data, out_last, out_dest, drop_err
    );
endinterface
`default_nettype wire

// File: rtl/arb_requester.sv
`default_nettype none
// ============================================================================
// Module  : arb_requester
// Purpose : Round-robin arbitration requester for one switch input port.
//           Optional starve flag enabled by macro ARB_REQ_STARVE_EN.
// Rev     : 1.0
// ============================================================================
module arb_requester #(
    parameter int NUM_OUTPUTS  = 4,
    parameter int NUM_INPUTS   = 4,
    parameter int PORT_ID      = 0,
    parameter int FLIT_W       = 32,
    parameter int DEST_W       = 4
`ifdef ARB_REQ_STARVE_EN
    ,
    parameter int STARVE_LIMIT = 255
`endif
) (
    input  logic            CLK,
    input  logic            nRST,
`ifdef ARB_REQ_STARVE_EN
    output logic            starve,
`endif
    arb_requester_if.master bus
);
    localparam int               SEL_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [SEL_W-1:0] MY_SEL = SEL_W'(PORT_ID);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BID     = 3'd1,
        XFER    = 3'd2,
        RELEASE = 3'd3,
        DROP    = 3'd4
    } state_t;

    state_t                 state, state_nx;
    logic [DEST_W-1:0]      dest_q, dest_nx, head_dest;
    logic [NUM_OUTPUTS-1:0] bid_q, bid_nx;
    logic                   drop_err_q, drop_err_nx;
    logic                   head_ok, grant, pick_valid;
    logic [SEL_W-1:0]       pick_sel;
    logic [FLIT_W-1:0]      xfer_data;

    assign head_dest = bus.in_data[DEST_W-1:0];
    assign head_ok   = 32'(head_dest) < NUM_OUTPUTS;

    // Only the arbiter of the latched destination can grant us
    always_comb begin
        pick_valid = 1'b0;
        pick_sel   = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            if (32'(dest_q) == 32'(o)) begin
                pick_valid = bus.sel_valid[o];
                pick_sel   = bus.sel[o*SEL_W +: SEL_W];
            end
        end
        grant = pick_valid && (pick_sel == MY_SEL);
    end

    always_comb begin
        state_nx      = state;
        dest_nx       = dest_q;
        drop_err_nx   = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        xfer_data     = '0;
        bid_nx        = '0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (head_ok) begin
                        dest_nx  = head_dest;
                        state_nx = BID;
                    end else begin
                        drop_err_nx = 1'b1;
                        state_nx    = DROP;
                    end
                end
            end
            BID: begin
                if (grant) state_nx = XFER;
            end
            XFER: begin
                bus.out_valid = bus.in_valid;
                bus.out_last  = bus.in_last;
                xfer_data     = bus.in_data;
                bus.in_ready  = bus.out_ready;
                if (bus.in_valid && bus.out_ready && bus.in_last) state_nx = RELEASE;
            end
            // One bid-free cycle lets the arbiter register the drop before any re-bid
            RELEASE: state_nx = IDLE;
            DROP: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            bid_nx[o] = ((state_nx == BID) || (state_nx == XFER)) && (32'(dest_nx) == 32'(o));
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            dest_q     <= '0;
            bid_q      <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state      <= state_nx;
            dest_q     <= dest_nx;
            bid_q      <= bid_nx;
            drop_err_q <= drop_err_nx;
        end
    end

    assign bus.bid      = bid_q;
    assign bus.drop_err = drop_err_q;
    assign bus.out_dest = dest_q;
    assign bus.out_data = xfer_data;

`ifdef ARB_REQ_STARVE_EN
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt <= '0;
        end else if ((state != BID) || (state_nx != BID)) begin
            wait_cnt <= '0;
        end else if (wait_cnt < LIMIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign starve = (state == BID) && (wait_cnt >= LIMIT);
`endif
endmodule
`default_nettype wire
